// File: rtl/edge_arb_pkg.sv
// Shared types and defaults for the edge event arbiter.
// EDGE_ARB_OVERFLOW_EN enables the sticky per-channel overflow flags.
package edge_arb_pkg;

   localparam int unsigned NUM_CH_DEFAULT = 4;

   typedef enum logic {
      IDLE,
      OFFER
   } state_t;

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event offer handshake plus per-channel status between arbiter (master) and consumer (slave).
// EDGE_ARB_OVERFLOW_EN adds the ovf status vector.
interface edge_event_arbiter_if
   import edge_arb_pkg::*;
#(
   parameter int unsigned NUM_CH = NUM_CH_DEFAULT,
   parameter int unsigned CH_W   = $clog2(NUM_CH)
);

   logic              evt_valid;
   logic              evt_ready;
   logic [CH_W-1:0]   evt_ch;
   logic [NUM_CH-1:0] pending;
`ifdef EDGE_ARB_OVERFLOW_EN
   logic [NUM_CH-1:0] ovf;

   modport master (output evt_valid, output evt_ch, output pending, output ovf, input evt_ready);
   modport slave  (input evt_valid, input evt_ch, input pending, input ovf, output evt_ready);
`else
   modport master (output evt_valid, output evt_ch, output pending, input evt_ready);
   modport slave  (input evt_valid, input evt_ch, input pending, output evt_ready);
`endif

endinterface

// File: rtl/edge_event_channel.sv
// One monitored line: rising-edge pulse, outstanding-event flag and optional overflow flag.
// EDGE_ARB_OVERFLOW_EN adds the sticky ovf output.
module edge_event_channel
   import edge_arb_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic din,
   input  logic clr,
   output logic pending
`ifdef EDGE_ARB_OVERFLOW_EN
   ,
   output logic ovf
`endif
);

   logic din_dly;
   logic edge_q;

   // A new edge beats a same-cycle handshake clear so that event is not lost.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         din_dly <= 1'b0;
         edge_q  <= 1'b0;
         pending <= 1'b0;
      end else begin
         din_dly <= din;
         edge_q  <= din & ~din_dly;
         if (edge_q)
            pending <= 1'b1;
         else if (clr)
            pending <= 1'b0;
      end
   end

`ifdef EDGE_ARB_OVERFLOW_EN
   always_ff @(posedge clk) begin
      if (!resetn)
         ovf <= 1'b0;
      else if (edge_q && pending && !clr)
         ovf <= 1'b1;
   end
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// Round-robin arbiter turning rising edges on NUM_CH lines into single handshaked events.
// EDGE_ARB_OVERFLOW_EN exposes sticky per-channel overflow flags for merged edges.
module edge_event_arbiter
   import edge_arb_pkg::*;
#(
   parameter int unsigned NUM_CH = NUM_CH_DEFAULT,
   parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NUM_CH-1:0]      din,
   edge_event_arbiter_if.master   evt
);

   state_t            state, state_nxt;
   logic              valid_q, valid_nxt;
   logic [CH_W-1:0]   ch_q, ch_nxt;
   logic [CH_W-1:0]   rr_ptr, rr_nxt;
   logic [CH_W-1:0]   winner;
   logic              hs;
   logic [NUM_CH-1:0] clr;
   logic [NUM_CH-1:0] pend;
`ifdef EDGE_ARB_OVERFLOW_EN
   logic [NUM_CH-1:0] ovf_v;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      edge_event_channel u_ch (
         .clk     (clk),
         .resetn  (resetn),
         .din     (din[i]),
         .clr     (clr[i]),
         .pending (pend[i])
`ifdef EDGE_ARB_OVERFLOW_EN
         ,
         .ovf     (ovf_v[i])
`endif
      );
   end

   assign evt.evt_valid = valid_q;
   assign evt.evt_ch    = ch_q;
   assign evt.pending   = pend;
`ifdef EDGE_ARB_OVERFLOW_EN
   assign evt.ovf       = ovf_v;
`endif

   assign hs = (state == OFFER) && evt.evt_ready;

   always_comb begin
      clr = '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         clr[i] = hs && (ch_q == CH_W'(i));
   end

   // Scan from rr_ptr upward, wrapping, and take the first pending channel.
   always_comb begin
      logic        found;
      logic [31:0] idx;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         idx = (32'(rr_ptr) + k) % NUM_CH;
         if (!found && pend[idx[CH_W-1:0]]) begin
            winner = idx[CH_W-1:0];
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      valid_nxt = valid_q;
      ch_nxt    = ch_q;
      rr_nxt    = rr_ptr;
      case (state)
         IDLE: begin
            if (|pend) begin
               ch_nxt    = winner;
               valid_nxt = 1'b1;
               state_nxt = OFFER;
            end else begin
               valid_nxt = 1'b0;
            end
         end
         OFFER: begin
            if (evt.evt_ready) begin
               valid_nxt = 1'b0;
               state_nxt = IDLE;
               rr_nxt    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         valid_q <= 1'b0;
         ch_q    <= '0;
         rr_ptr  <= '0;
      end else begin
         state   <= state_nxt;
         valid_q <= valid_nxt;
         ch_q    <= ch_nxt;
         rr_ptr  <= rr_nxt;
      end
   end

endmodule
